// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - two-stage pipelined adder/subtractor with valid/ready flow control and optional accumulator (ADDER_PIPE_ACCUM_EN)
module adder_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    // S1 state: high halves of the mapped operands plus the finished low half
    logic          s1_valid_q, s1_valid_d;
    logic [HI-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [HI-1:0] s1_b_hi_q, s1_b_hi_d;
    logic [LO-1:0] s1_lo_q, s1_lo_d;
    logic          s1_c_q, s1_c_d;

    // S2 state: the registered result
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

`ifdef ADDER_PIPE_ACCUM_EN
    logic             s1_acc_q, s1_acc_d;
    logic             s1_clr_q, s1_clr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    logic [1:0]       mode_eff;
    logic [WIDTH-1:0] op_a, op_b;
    logic             c0;
    logic [LO:0]      lo_full;
    logic [HI:0]      hi_full;
    logic [WIDTH-1:0] res;
    logic             res_cout, res_ovf;
    logic             s2_adv, s1_adv, accept, acc_hazard;

    // Operand mapping per mode and the low-half partial sum feeding S1
    always_comb begin
`ifdef ADDER_PIPE_ACCUM_EN
        mode_eff = mode;
`else
        // Without the accumulator, mode[1] carries no meaning: 10 is add, 11 is sub
        mode_eff = mode & 2'b01;
`endif
        op_a = a;
        op_b = b;
        c0   = cin;
        case (mode_eff)
            2'b01: begin
                op_b = ~b;
                c0   = 1'b1;
            end
`ifdef ADDER_PIPE_ACCUM_EN
            2'b10: begin
                op_b = acc_q;
            end
            2'b11: begin
                // Read-and-clear: acc + 0 + 0 reproduces acc with no carry/overflow
                op_a = acc_q;
                op_b = '0;
                c0   = 1'b0;
            end
`endif
            default: begin
                op_a = a;
                op_b = b;
                c0   = cin;
            end
        endcase
        lo_full = {1'b0, op_a[LO-1:0]} + {1'b0, op_b[LO-1:0]} + {{LO{1'b0}}, c0};
    end

    // High-half completion in S2 using the carry saved in S1
    always_comb begin
        hi_full  = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{HI{1'b0}}, s1_c_q};
        res      = {hi_full[HI-1:0], s1_lo_q};
        res_cout = hi_full[HI];
        res_ovf  = (s1_a_hi_q[HI-1] == s1_b_hi_q[HI-1]) && (res[WIDTH-1] != s1_a_hi_q[HI-1]);
    end

    // Handshake and next-state for both stages and the accumulator
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = s1_valid_q && s2_adv;
`ifdef ADDER_PIPE_ACCUM_EN
        // acc is only up to date once the acc op in S1 has reached S2
        acc_hazard = s1_valid_q && s1_acc_q && mode_eff[1];
`else
        acc_hazard = 1'b0;
`endif
        in_ready = !rst && (!s1_valid_q || s1_adv) && !acc_hazard;
        accept   = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_a_hi_d  = s1_a_hi_q;
        s1_b_hi_d  = s1_b_hi_q;
        s1_lo_d    = s1_lo_q;
        s1_c_d     = s1_c_q;
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_hi_d  = op_a[WIDTH-1:LO];
            s1_b_hi_d  = op_b[WIDTH-1:LO];
            s1_lo_d    = lo_full[LO-1:0];
            s1_c_d     = lo_full[LO];
        end

        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            sum_d  = res;
            cout_d = res_cout;
            ovf_d  = res_ovf;
        end

`ifdef ADDER_PIPE_ACCUM_EN
        s1_acc_d = s1_acc_q;
        s1_clr_d = s1_clr_q;
        acc_d    = acc_q;
        if (accept) begin
            s1_acc_d = mode_eff[1];
            s1_clr_d = mode_eff[1] && mode_eff[0];
        end
        if (s1_adv && s1_acc_q) begin
            acc_d = s1_clr_q ? '0 : res;
        end
`endif
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_b_hi_q  <= '0;
            s1_lo_q    <= '0;
            s1_c_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef ADDER_PIPE_ACCUM_EN
            s1_acc_q   <= 1'b0;
            s1_clr_q   <= 1'b0;
            acc_q      <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_hi_q  <= s1_a_hi_d;
            s1_b_hi_q  <= s1_b_hi_d;
            s1_lo_q    <= s1_lo_d;
            s1_c_q     <= s1_c_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
`ifdef ADDER_PIPE_ACCUM_EN
            s1_acc_q   <= s1_acc_d;
            s1_clr_q   <= s1_clr_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe (WIDTH=8), follows ADDER_PIPE_ACCUM_EN
module tb_adder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       cin;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    adder_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [9:0] exp_q[$];
    logic [7:0] acc_m = 8'h00;
    logic last_ov, last_ir, got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: result as {sum, cout, ovf}, computed from signed/unsigned integer arithmetic
    function automatic logic [9:0] model(input logic [7:0] xa, input logic [7:0] xb,
                                         input logic xc, input logic [1:0] xm);
        int ua, ub, r, sa, sb, s;
        logic [1:0] m;
        logic [7:0] rs;
        logic co, ov;
`ifdef ADDER_PIPE_ACCUM_EN
        m = xm;
`else
        m = xm & 2'b01;
`endif
        ua = int'(xa);
        sa = int'($signed(xa));
        ub = (m == 2'b10) ? int'(acc_m) : int'(xb);
        sb = (m == 2'b10) ? int'($signed(acc_m)) : int'($signed(xb));
        if (m == 2'b01) begin
            r  = ua - ub;
            co = (ua >= ub);
            s  = sa - sb;
            ov = (s > 127) || (s < -128);
            rs = r[7:0];
        end else if (m == 2'b11) begin
            rs = acc_m;
            co = 1'b0;
            ov = 1'b0;
            acc_m = 8'h00;
        end else begin
            r  = ua + ub + int'(xc);
            co = (r > 255);
            s  = sa + sb + int'(xc);
            ov = (s > 127) || (s < -128);
            rs = r[7:0];
            if (m == 2'b10) acc_m = rs;
        end
        return {rs, co, ov};
    endfunction

    // One clock: drive at negedge, sample 1ns later, score pops and accepts for the coming edge
    task automatic step(input logic iv, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xc, input logic [1:0] xm, input logic ordy,
                        output logic accepted);
        @(negedge clk);
        in_valid = iv; a = xa; b = xb; cin = xc; mode = xm; out_ready = ordy;
        #1;
        last_ov = out_valid;
        last_ir = in_ready;
        if (out_valid) begin
            chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("result", 32'({sum, cout, ovf}), 32'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
        accepted = iv && in_ready;
        if (accepted) exp_q.push_back(model(xa, xb, xc, xm));
    endtask

    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        input logic [1:0] xm, input logic ordy);
        logic acc_f;
        acc_f = 1'b0;
        for (int i = 0; i < 20 && !acc_f; i++) step(1'b1, xa, xb, xc, xm, ordy, acc_f);
        chk("send_accepted", 32'(acc_f), 32'd1);
    endtask

    task automatic drain();
        logic d;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, d);
        step(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, d);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(last_ov), 32'd0);
    endtask

    logic [7:0] bp_a[5];
    logic [7:0] bp_b[5];
    int idx, stalls;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 2'b00; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", 32'({cout, ovf}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Add with latency check: accepted at edge N, visible only after edge N+1
        step(1'b1, 8'h01, 8'h02, 1'b0, 2'b00, 1'b1, got);
        chk("add_accept", 32'(got), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, got);
        chk("latency_not_yet", 32'(last_ov), 32'd0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, got);
        chk("latency_valid", 32'(last_ov), 32'd1);

        // Directed add/sub corners, back-to-back at full rate
        send(8'hFF, 8'h01, 1'b1, 2'b00, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 2'b00, 1'b1);
        send(8'h05, 8'h07, 1'b0, 2'b01, 1'b1);
        send(8'h80, 8'h01, 1'b0, 2'b01, 1'b1);
        send(8'h05, 8'h07, 1'b1, 2'b01, 1'b1);
        send(8'h80, 8'h01, 1'b1, 2'b01, 1'b1);
        drain();

        // Backpressure: 5 beats, consumer stalled for 6 cycles
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = 8'($urandom);
            bp_b[i] = 8'($urandom);
        end
        idx = 0;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bp_a[idx], bp_b[idx], 1'b0, 2'b00, 1'b0, got);
            if (got) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(last_ir), 32'd0);
        for (int i = 0; i < 30 && idx < 5; i++) begin
            step(1'b1, bp_a[idx], bp_b[idx], 1'b0, 2'b00, 1'b1, got);
            if (got) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd5);
        drain();
        chk("bp_pops", 32'(pops), 32'd5);

`ifdef ADDER_PIPE_ACCUM_EN
        // Back-to-back acc beats stall one cycle between each pair
        idx = 0;
        stalls = 0;
        for (int i = 0; i < 20 && idx < 3; i++) begin
            step(1'b1, 8'(8'h10 * (idx + 1)), 8'h00, 1'b0, 2'b10, 1'b1, got);
            if (got) idx++;
            else stalls++;
        end
        chk("acc_sent", 32'(idx), 32'd3);
        chk("acc_stalls", 32'(stalls), 32'd2);
        send(8'h00, 8'h00, 1'b0, 2'b11, 1'b1);
        send(8'h05, 8'h00, 1'b0, 2'b10, 1'b1);
        drain();
`else
        // mode 10 is plain add and never stalls
        step(1'b1, 8'h03, 8'h04, 1'b0, 2'b10, 1'b1, got);
        chk("m10_accept0", 32'(got), 32'd1);
        step(1'b1, 8'h03, 8'h04, 1'b0, 2'b10, 1'b1, got);
        chk("m10_accept1", 32'(got), 32'd1);
        drain();
`endif

        // Randomized traffic across all modes with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom_range(0, 3) != 0), got);
        end
        drain();

        // Reset mid-flight with both stages occupied
        send(8'h00, 8'h00, 1'b0, 2'b11, 1'b1);
        send(8'h40, 8'h00, 1'b0, 2'b10, 1'b1);
        drain();
        send(8'h11, 8'h22, 1'b0, 2'b00, 1'b0);
        send(8'h33, 8'h44, 1'b0, 2'b00, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, got);
        chk("full_in_ready_low", 32'(last_ir), 32'd0);
        chk("full_out_valid", 32'(last_ov), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        acc_m = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        send(8'h01, 8'h00, 1'b0, 2'b10, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, two-stage pipelined adder/subtractor with valid/ready handshakes on both sides, plus an optional accumulator. It is the next generation of the team's small combinational adder: it is generalised to WIDTH bits, adds an operating mode, signed-overflow detection and backpressure, and is registered so it can sit directly on a datapath between a producer and a consumer. Verification drives it through an interface, like the adder bench.

## Interface
- WIDTH, 8: operand and result width in bits; must be >= 2. The low half is LO = WIDTH/2 (floor).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high; clears all state.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; used in add and accumulate modes only.
- mode  in  2  operation select: 00 add, 01 sub, 10 acc, 11 acc read-and-clear.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out (add/acc) or not-borrow (sub).
- ovf  out  1  two's-complement signed overflow.

## Operation
- **Accept rule:** a beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- **Stage 1 (S1) register** captures:
  - mode and the high halves of the operands;
  - the low-half partial sum a[LO-1:0] + b'[LO-1:0] + c0, and its carry.
- **Stage 2 / output (S2) register** completes the high half using the S1 carry, then registers sum, cout and ovf.
- **Operand mapping:**
  - add: b' = b, c0 = cin.
  - sub: b' = ~b, c0 = 1; cin is ignored.
  - acc: the op computes acc + a + cin, with the accumulator in place of b.
  - read-and-clear: the result is acc; acc is then cleared.
- **Arithmetic:**
  - sum is result mod 2^WIDTH; cout is the bit WIDTH carry.
  - ovf = (opA[W-1] == b'[W-1]) && (sum[W-1] != opA[W-1]), where opA is the first operand (a, or acc in read-and-clear mode).
- **Flow control:**
  - S2 advances when !S2_valid || out_ready.
  - S1 advances into S2 when S1_valid && S2 can advance.
  - in_ready = (!S1_valid || S1 advances) && !acc_hazard.
  - An S2 result is held stable while out_valid && !out_ready.
- **Accumulator:**
  - acc is a WIDTH-bit register.
  - It is written with the S2 result when an acc op loads S2, and cleared when a read-and-clear op loads S2.
  - acc_hazard = an acc-mode op (10/11) is in S1 and the incoming beat is acc-mode. Non-acc beats never stall on the hazard.
- **Ordering:** results leave in acceptance order; no beat is dropped or duplicated.

## Timing
- **Reset values:** out_valid=0, sum=0, cout=0, ovf=0, acc=0, S1_valid=0.
  - in_ready=1 while rst is low and the block is empty.
  - in_ready=0 while rst is asserted.
- **Latency:** a beat accepted at edge N gives out_valid high after edge N+1, i.e. 2 cycles from presentation.
- **Throughput:**
  - 1 beat per cycle for add/sub.
  - 1 acc beat per 2 cycles when acc beats are back-to-back.
- **Full pipeline:** with both stages valid and out_ready=0, in_ready=0. Capacity is 2 beats.
- **Simultaneous events:** an output pop and an input accept in the same cycle keep full throughput.
- **Reset mid-operation:** in-flight beats are discarded and all outputs go to their reset values immediately (asynchronously).
- **Wrap-around:** sum and acc wrap modulo 2^WIDTH with no saturation; overflow is reported only through cout and ovf.

## Configuration
- ADDER_PIPE_ACCUM_EN
  - Defined: the accumulator, modes 10/11 and the hazard stall are present.
  - Undefined: there is no acc register and no hazard; mode[1] is ignored, so 10 behaves as add and 11 as sub.

## Test plan
All scenarios use WIDTH=8.
- **Add:**
  - a=0x01, b=0x02, cin=0 -> two cycles later sum=0x03, cout=0, ovf=0.
  - a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1.
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1.
- **Sub:**
  - a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
  - Both results are unaffected by cin=1.
- **Backpressure:** stream 5 add beats with out_ready=0 for 6 cycles -> in_ready drops after 2 accepts; the held output is stable; after release all 5 results emerge in order, with no loss or duplication.
- **Accumulate (macro on):**
  - Send mode 10 with a=0x10, 0x20, 0x30, cin=0, back-to-back -> sums 0x10, 0x30, 0x60, with in_ready low for 1 cycle between each pair.
  - Then mode 11 -> sum=0x60.
  - Then mode 10 with a=0x05 -> sum=0x05.
- **Macro off:** mode 10 with a=0x03, b=0x04 -> sum=0x07; no stall.
- **Reset mid-flight:** assert rst with S1 and S2 both valid and acc=0x40 -> out_valid=0 before the next edge; after release, mode 10 with a=0x01 -> sum=0x01.
